// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared constants and helpers for the interrupt controller.
//   DEF_NUM_SRC    : default number of interrupt sources
//   MAX_SRC        : widest source vector the priority encoder accepts
//   DEF_VEC_BASE   : default vector address of source 0
//   DEF_VEC_STRIDE : default spacing between consecutive vectors
//   lowest_set()   : index of the lowest set bit among the first n bits,
//                    or n when none of them is set
// ---------------------------------------------------------------------------
package irq_pkg;

  localparam int          DEF_NUM_SRC    = 3;
  localparam int          MAX_SRC        = 32;
  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0C00;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0100;

  // Index 0 is the highest priority, so "highest priority set" is simply
  // the lowest set bit. Scanning downward lets the lowest index win.
  function automatic int lowest_set(input logic [MAX_SRC-1:0] bits, input int n);
    int idx;
    idx = n;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (i < n && bits[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// ---------------------------------------------------------------------------
// irq_edge_detect
// Keeps a registered copy of the raw request levels and flags a rising edge
// per source.
//   clk    : clock
//   irq_in : raw request levels
//   rise   : irq_in & ~prev, one bit per source (combinational)
// ---------------------------------------------------------------------------
module irq_edge_detect #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic [N-1:0] irq_in,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev;

  // Reset also loads prev from irq_in, so the register needs no reset
  // branch: a level held high through reset never looks like an edge.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its inputs; = here would create order-dependent races.
  always_ff @(posedge clk) begin
    prev <= irq_in;
  end

  assign rise = irq_in & ~prev;

endmodule

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
// Edge-triggered, fixed-priority, nesting interrupt controller with a
// hardware return-address stack.
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   en        : CPU advancing (~halt); gates takes and returns
//   irqIn     : raw request levels, a rising edge requests service
//   pcNext    : address the CPU would fetch next (saved on a take)
//   mret      : current instruction is a return-from-interrupt
//   irqTake   : combinational, CPU loads PC from irqTarget when 1
//   irqTarget : vector address or return address, 0 when irqTake=0
//   pending   : registered pending bits
//   inService : registered in-service bits
// ---------------------------------------------------------------------------
module irq_controller
  import irq_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          NUM_SRC    = DEF_NUM_SRC,
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_SRC-1:0] irqIn,
  input  logic [WIDTH-1:0]   pcNext,
  input  logic               mret,
  output logic               irqTake,
  output logic [WIDTH-1:0]   irqTarget,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] inService
);

  localparam int                 PTR_W = $clog2(NUM_SRC + 1);
  localparam logic [PTR_W-1:0]   DEPTH = PTR_W'(NUM_SRC);
  localparam logic [PTR_W-1:0]   ONE   = PTR_W'(1);

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] p_bit;
  logic [NUM_SRC-1:0] s_bit;
  int                 p_idx;
  int                 s_idx;
  logic               take_ok;
  logic               ret_ok;

  logic [WIDTH-1:0]   stack [NUM_SRC];
  logic [PTR_W-1:0]   sp;

  irq_edge_detect #(.N(NUM_SRC)) u_edge (
    .clk    (clk),
    .irq_in (irqIn),
    .rise   (rise)
  );

  // x & -x isolates the lowest set bit: the one-hot form of P and S.
  assign p_bit = pending   & (~pending   + NUM_SRC'(1));
  assign s_bit = inService & (~inService + NUM_SRC'(1));

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    p_idx     = lowest_set(MAX_SRC'(pending), NUM_SRC);
    s_idx     = lowest_set(MAX_SRC'(inService), NUM_SRC);
    // Nesting only by strictly higher priority; a return wins over a take.
    ret_ok    = en && mret && (|inService);
    take_ok   = en && !mret && (|pending) && (p_idx < s_idx);
    irqTake   = ret_ok || take_ok;
    irqTarget = '0;
    if (ret_ok) begin
      irqTarget = stack[sp - ONE];
    end else if (take_ok) begin
      irqTarget = WIDTH'(VEC_BASE) + WIDTH'(p_idx) * WIDTH'(VEC_STRIDE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      inService <= '0;
      sp        <= '0;
      // NOTE: the stack entries are cleared too so no stale return address
      // survives a reset; storage arrays are normally left unreset.
      for (int i = 0; i < NUM_SRC; i++) stack[i] <= '0;
    end else begin
      // Edge capture runs regardless of en. A new edge on the source being
      // taken re-arms it, so it is serviced again after its return.
      pending <= (pending & ~(take_ok ? p_bit : '0)) | rise;
      if (ret_ok) begin
        inService <= inService & ~s_bit;
        if (sp != '0) sp <= sp - ONE;
      end else if (take_ok) begin
        inService <= inService | p_bit;
        // Each source is in service at most once, so the stack cannot
        // overflow; the guard only keeps the pointer saturated.
        if (sp < DEPTH) begin
          stack[sp] <= pcNext;
          sp        <= sp + ONE;
        end
      end
    end
  end

endmodule
